// File: rtl/dram_bank_timing_ctrl.sv
// ============================================================================
// Module   : dram_bank_timing_ctrl
// Brief    : Per-bank ACT/RD/WR/PRE window timers, all-bank refresh window
//            timer and tREFI-driven refresh debt counter with postponement.
// Revision : 1.0 - initial multi-bank release
// ============================================================================
`default_nettype none

module dram_bank_timing_ctrl #(
   parameter int NUM_BANKS    = 4,
   parameter int T_RCD        = 14,
   parameter int T_RD         = 8,
   parameter int T_WR         = 16,
   parameter int T_RP         = 14,
   parameter int T_RFC        = 64,
   parameter int T_REFI       = 3900,
   parameter int MAX_POSTPONE = 8,
   parameter int CNT_W        = $clog2(
      ((T_RCD > T_RD ? T_RCD : T_RD) > (T_WR > T_RP ? T_WR : T_RP)) ?
      (((T_RCD > T_RD ? T_RCD : T_RD) > T_RFC) ? (T_RCD > T_RD ? T_RCD : T_RD) : T_RFC) :
      (((T_WR > T_RP ? T_WR : T_RP) > T_RFC) ? (T_WR > T_RP ? T_WR : T_RP) : T_RFC)) + 1
) (
   input  logic                                           CLK,
   input  logic                                           nRST,
   input  logic                                           cmd_valid,
   input  logic [2:0]                                     cmd_type,
   input  logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] cmd_bank,
   output logic [NUM_BANKS-1:0]                           tACT_done,
   output logic [NUM_BANKS-1:0]                           tRD_done,
   output logic [NUM_BANKS-1:0]                           tWR_done,
   output logic [NUM_BANKS-1:0]                           tPRE_done,
   output logic                                           tREF_done,
   output logic                                           rf_req,
   output logic                                           rf_urgent,
   output logic [$clog2(MAX_POSTPONE+1)-1:0]              ref_owed,
   output logic [NUM_BANKS-1:0]                           bank_busy,
   output logic                                           cmd_err
);

   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int OWED_W = $clog2(MAX_POSTPONE+1);
   localparam int REFI_W = $clog2(T_REFI+1);

   localparam logic [2:0] c_CMD_ACT = 3'd0;
   localparam logic [2:0] c_CMD_RD  = 3'd1;
   localparam logic [2:0] c_CMD_WR  = 3'd2;
   localparam logic [2:0] c_CMD_PRE = 3'd3;
   localparam logic [2:0] c_CMD_REF = 3'd4;

   typedef enum logic [2:0] {OP_NONE, OP_ACT, OP_RD, OP_WR, OP_PRE} op_e;

   logic [CNT_W-1:0]  r_bankCnt [NUM_BANKS];
   op_e               r_lastOp  [NUM_BANKS];
   logic [CNT_W-1:0]  r_refCnt;
   logic              r_refLast;
   logic [REFI_W-1:0] r_refiCnt;
   logic [OWED_W-1:0] r_refOwed;
   logic              r_rfReq;
   logic              r_rfUrgent;
   logic              r_cmdErr;

   logic [NUM_BANKS-1:0] w_busy;
   logic              w_refActive, w_isRef, w_anyBusy, w_bankHit, w_targetBusy;
   logic              w_accept, w_refAcc, w_tick;
   logic [CNT_W-1:0]  w_loadVal;
   op_e               w_loadOp;
   logic [OWED_W-1:0] w_owedNext;

   generate
      for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
         assign w_busy[b]    = (r_bankCnt[b] != '0);
         assign tACT_done[b] = (r_lastOp[b] == OP_ACT) && !w_busy[b] && !w_refActive;
         assign tRD_done[b]  = (r_lastOp[b] == OP_RD)  && !w_busy[b] && !w_refActive;
         assign tWR_done[b]  = (r_lastOp[b] == OP_WR)  && !w_busy[b] && !w_refActive;
         assign tPRE_done[b] = (r_lastOp[b] == OP_PRE) && !w_busy[b] && !w_refActive;
      end
   endgenerate

   assign w_refActive = (r_refCnt != '0);
   assign w_isRef     = (cmd_type == c_CMD_REF);
   assign w_anyBusy   = |w_busy;
   assign w_tick      = (r_refiCnt == '0);

   // Bank indices beyond NUM_BANKS (non-power-of-two configs) never match and are rejected.
   always_comb begin
      w_bankHit    = 1'b0;
      w_targetBusy = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (cmd_bank == BANK_W'(b)) begin
            w_bankHit    = 1'b1;
            w_targetBusy = w_busy[b];
         end
      end
   end

   assign w_accept = cmd_valid && (cmd_type <= c_CMD_REF) && !w_refActive &&
                     (w_isRef ? !w_anyBusy : (w_bankHit && !w_targetBusy));
   assign w_refAcc = w_accept && w_isRef;

   // Counters load the full window length so done rises exactly T_X edges after issue.
   always_comb begin
      w_loadVal = CNT_W'(T_RCD);
      w_loadOp  = OP_ACT;
      case (cmd_type)
         c_CMD_RD:  begin w_loadVal = CNT_W'(T_RD); w_loadOp = OP_RD;  end
         c_CMD_WR:  begin w_loadVal = CNT_W'(T_WR); w_loadOp = OP_WR;  end
         c_CMD_PRE: begin w_loadVal = CNT_W'(T_RP); w_loadOp = OP_PRE; end
         default:   ;
      endcase
   end

   always_comb begin
      w_owedNext = r_refOwed;
      if (w_tick && !w_refAcc && (r_refOwed != OWED_W'(MAX_POSTPONE)))
         w_owedNext = r_refOwed + OWED_W'(1);
      else if (w_refAcc && !w_tick && (r_refOwed != '0))
         w_owedNext = r_refOwed - OWED_W'(1);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            r_bankCnt[b] <= '0;
            r_lastOp[b]  <= OP_NONE;
         end
         r_refCnt   <= '0;
         r_refLast  <= 1'b0;
         r_refiCnt  <= REFI_W'(T_REFI-1);
         r_refOwed  <= '0;
         r_rfReq    <= 1'b0;
         r_rfUrgent <= 1'b0;
         r_cmdErr   <= 1'b0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_accept && !w_isRef && (cmd_bank == BANK_W'(b))) begin
               r_bankCnt[b] <= w_loadVal;
               r_lastOp[b]  <= w_loadOp;
            end else begin
               if (w_busy[b])
                  r_bankCnt[b] <= r_bankCnt[b] - CNT_W'(1);
               if (w_refAcc)
                  r_lastOp[b] <= OP_NONE;
            end
         end

         if (w_refAcc) begin
            r_refCnt  <= CNT_W'(T_RFC);
            r_refLast <= 1'b1;
         end else begin
            if (w_refActive)
               r_refCnt <= r_refCnt - CNT_W'(1);
            if (w_accept)
               r_refLast <= 1'b0;
         end

         r_refiCnt  <= w_tick ? REFI_W'(T_REFI-1) : r_refiCnt - REFI_W'(1);
         r_refOwed  <= w_owedNext;
         r_rfReq    <= (w_owedNext != '0);
         r_rfUrgent <= (w_owedNext == OWED_W'(MAX_POSTPONE));
         r_cmdErr   <= cmd_valid && !w_accept;
      end
   end

   assign tREF_done = r_refLast && !w_refActive;
   assign rf_req    = r_rfReq;
   assign rf_urgent = r_rfUrgent;
   assign ref_owed  = r_refOwed;
   assign bank_busy = w_busy;
   assign cmd_err   = r_cmdErr;

endmodule

`default_nettype wire

// File: tb/tb_dram_bank_timing_ctrl.sv
// ============================================================================
// Module   : tb_dram_bank_timing_ctrl
// Brief    : Directed self-checking bench for dram_bank_timing_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_bank_timing_ctrl;

   localparam int NB = 4;
   localparam logic [2:0] ACT = 3'd0, RD = 3'd1, WR = 3'd2, PRE = 3'd3, REF = 3'd4;

   logic       CLK = 1'b0;
   logic       nRST = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd_type = 3'd0;
   logic [1:0] cmd_bank = 2'd0;
   logic [NB-1:0] tACT_done, tRD_done, tWR_done, tPRE_done, bank_busy;
   logic       tREF_done, rf_req, rf_urgent, cmd_err;
   logic [1:0] ref_owed;

   int checks = 0;
   int errors = 0;
   int edgeN  = 0;

   dram_bank_timing_ctrl #(
      .NUM_BANKS(NB), .T_RCD(3), .T_RD(2), .T_WR(4), .T_RP(3),
      .T_RFC(5), .T_REFI(10), .MAX_POSTPONE(2)
   ) dut (
      .CLK(CLK), .nRST(nRST), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
      .cmd_bank(cmd_bank), .tACT_done(tACT_done), .tRD_done(tRD_done),
      .tWR_done(tWR_done), .tPRE_done(tPRE_done), .tREF_done(tREF_done),
      .rf_req(rf_req), .rf_urgent(rf_urgent), .ref_owed(ref_owed),
      .bank_busy(bank_busy), .cmd_err(cmd_err)
   );

   always #5 CLK = ~CLK;

   // Edge numbering: edge 1 is the first rising edge after reset release.
   task automatic step();
      @(posedge CLK);
      #1;
      edgeN++;
   endtask

   task automatic stepTo(input int n);
      while (edgeN < n) step();
   endtask

   task automatic issue(input logic [2:0] t, input logic [1:0] b);
      cmd_valid = 1'b1;
      cmd_type  = t;
      cmd_bank  = b;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic doReset();
      nRST = 1'b0;
      cmd_valid = 1'b0;
      step();
      step();
      nRST = 1'b1;
      edgeN = 0;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      #2;
      checks++; if ({tACT_done, tRD_done, tWR_done, tPRE_done} !== 16'h0) begin errors++; $display("FAIL reset_done: got %h expected 0000", {tACT_done, tRD_done, tWR_done, tPRE_done}); end
      checks++; if ({tREF_done, rf_req, rf_urgent, cmd_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {tREF_done, rf_req, rf_urgent, cmd_err}); end
      checks++; if (ref_owed !== 2'd0) begin errors++; $display("FAIL reset_owed: got %0d expected 0", ref_owed); end
      checks++; if (bank_busy !== 4'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0000", bank_busy); end
   endtask

   task automatic test_act();
      doReset();
      issue(ACT, 2'd0);
      stepTo(4);
      checks++; if (tACT_done !== 4'b0001) begin errors++; $display("FAIL act_b0_done: got %b expected 0001", tACT_done); end
      issue(ACT, 2'd2);
      checks++; if (tACT_done !== 4'b0001) begin errors++; $display("FAIL act_b2_issue_done: got %b expected 0001", tACT_done); end
      checks++; if (bank_busy !== 4'b0100) begin errors++; $display("FAIL act_b2_busy: got %b expected 0100", bank_busy); end
      stepTo(7);
      checks++; if ({bank_busy, tACT_done} !== 8'b0100_0001) begin errors++; $display("FAIL act_b2_edge7: got %b expected 01000001", {bank_busy, tACT_done}); end
      step();
      checks++; if ({bank_busy, tACT_done} !== 8'b0000_0101) begin errors++; $display("FAIL act_b2_edge8: got %b expected 00000101", {bank_busy, tACT_done}); end
      issue(PRE, 2'd0);
      checks++; if ({tACT_done, tPRE_done} !== 8'b0100_0000) begin errors++; $display("FAIL pre_issue: got %b expected 01000000", {tACT_done, tPRE_done}); end
      stepTo(12);
      checks++; if (tPRE_done !== 4'b0001) begin errors++; $display("FAIL pre_done: got %b expected 0001", tPRE_done); end
   endtask

   task automatic test_wr_rd();
      doReset();
      issue(WR, 2'd1);
      step();
      issue(RD, 2'd1);
      checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL rd_busy_err: got %b expected 1", cmd_err); end
      step();
      checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b expected 0", cmd_err); end
      step();
      checks++; if ({tWR_done, tRD_done} !== 8'b0010_0000) begin errors++; $display("FAIL wr_done: got %b expected 00100000", {tWR_done, tRD_done}); end
      issue(3'd5, 2'd0);
      checks++; if ({cmd_err, tWR_done} !== 5'b1_0010) begin errors++; $display("FAIL illegal_type: got %b expected 10010", {cmd_err, tWR_done}); end
      issue(RD, 2'd1);
      checks++; if ({cmd_err, tWR_done, tRD_done} !== 9'b0_0000_0000) begin errors++; $display("FAIL rd_issue: got %b expected 000000000", {cmd_err, tWR_done, tRD_done}); end
      stepTo(9);
      checks++; if (tRD_done !== 4'b0010) begin errors++; $display("FAIL rd_done: got %b expected 0010", tRD_done); end
   endtask

   task automatic test_refdebt();
      doReset();
      stepTo(9);
      checks++; if ({ref_owed, rf_req} !== 3'b00_0) begin errors++; $display("FAIL debt_edge9: got %b expected 000", {ref_owed, rf_req}); end
      step();
      checks++; if ({ref_owed, rf_req, rf_urgent} !== 4'b01_1_0) begin errors++; $display("FAIL debt_edge10: got %b expected 0110", {ref_owed, rf_req, rf_urgent}); end
      stepTo(20);
      checks++; if ({ref_owed, rf_req, rf_urgent} !== 4'b10_1_1) begin errors++; $display("FAIL debt_edge20: got %b expected 1011", {ref_owed, rf_req, rf_urgent}); end
      stepTo(30);
      checks++; if ({ref_owed, rf_urgent} !== 3'b10_1) begin errors++; $display("FAIL debt_saturate: got %b expected 101", {ref_owed, rf_urgent}); end
   endtask

   task automatic test_ref_tick();
      doReset();
      issue(ACT, 2'd0);
      stepTo(19);
      checks++; if ({ref_owed, tACT_done} !== 6'b01_0001) begin errors++; $display("FAIL preref_state: got %b expected 010001", {ref_owed, tACT_done}); end
      issue(REF, 2'd0);
      checks++; if ({ref_owed, tACT_done, tREF_done, cmd_err} !== 8'b01_0000_0_0) begin errors++; $display("FAIL ref_on_tick: got %b expected 01000000", {ref_owed, tACT_done, tREF_done, cmd_err}); end
      stepTo(24);
      checks++; if (tREF_done !== 1'b0) begin errors++; $display("FAIL ref_early: got %b expected 0", tREF_done); end
      step();
      checks++; if ({tREF_done, tACT_done} !== 5'b1_0000) begin errors++; $display("FAIL ref_done: got %b expected 10000", {tREF_done, tACT_done}); end
      issue(REF, 2'd0);
      checks++; if ({ref_owed, rf_req, tREF_done} !== 4'b00_0_0) begin errors++; $display("FAIL ref_pay_debt: got %b expected 0000", {ref_owed, rf_req, tREF_done}); end
   endtask

   task automatic test_reject();
      doReset();
      stepTo(10);
      issue(ACT, 2'd0);
      issue(REF, 2'd0);
      checks++; if ({cmd_err, ref_owed, tREF_done, bank_busy} !== 8'b1_01_0_0001) begin errors++; $display("FAIL ref_while_busy: got %b expected 10100001", {cmd_err, ref_owed, tREF_done, bank_busy}); end
      stepTo(14);
      issue(REF, 2'd0);
      checks++; if ({cmd_err, ref_owed} !== 3'b0_00) begin errors++; $display("FAIL ref_accept: got %b expected 000", {cmd_err, ref_owed}); end
      issue(ACT, 2'd1);
      checks++; if ({cmd_err, bank_busy} !== 5'b1_0000) begin errors++; $display("FAIL act_in_rfc: got %b expected 10000", {cmd_err, bank_busy}); end
      stepTo(20);
      checks++; if ({tREF_done, tACT_done} !== 5'b1_0000) begin errors++; $display("FAIL rfc_end: got %b expected 10000", {tREF_done, tACT_done}); end
      issue(ACT, 2'd1);
      checks++; if ({tREF_done, cmd_err, bank_busy} !== 6'b0_0_0010) begin errors++; $display("FAIL act_after_ref: got %b expected 000010", {tREF_done, cmd_err, bank_busy}); end
   endtask

   task automatic test_midreset();
      doReset();
      stepTo(10);
      issue(ACT, 2'd3);
      step();
      checks++; if ({bank_busy, ref_owed} !== 6'b1000_01) begin errors++; $display("FAIL prereset_state: got %b expected 100001", {bank_busy, ref_owed}); end
      #2;
      nRST = 1'b0;
      #1;
      checks++; if ({bank_busy, ref_owed, rf_req, tACT_done} !== 11'b0) begin errors++; $display("FAIL midreset_clear: got %b expected 0", {bank_busy, ref_owed, rf_req, tACT_done}); end
      step();
      nRST = 1'b1;
      edgeN = 0;
      stepTo(9);
      checks++; if ({ref_owed, tACT_done, bank_busy} !== 10'b0) begin errors++; $display("FAIL postreset_edge9: got %b expected 0", {ref_owed, tACT_done, bank_busy}); end
      step();
      checks++; if (ref_owed !== 2'd1) begin errors++; $display("FAIL postreset_tick: got %0d expected 1", ref_owed); end
   endtask

   initial begin
      test_reset();
      test_act();
      test_wr_rd();
      test_refdebt();
      test_ref_tick();
      test_reject();
      test_midreset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
